// File: rtl/fp_check_pkg.sv
// fp_check_pkg: shared types, constants and the result-compare rule for the
// fp_check result checker.
package fp_check_pkg;

    localparam logic [1:0]  FMT_SINGLE  = 2'd0;
    localparam logic [1:0]  FMT_DOUBLE  = 2'd1;

    // Canonical quiet NaNs produced by fp_unit
    localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
    localparam logic [63:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;

    // One expected-queue entry
    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic [1:0]  fmt;
        logic        nan_rlx;
    } fp_check_entry_t;

    // Issue-side and execute-side inputs
    typedef struct packed {
        logic            exp_valid;
        fp_check_entry_t exp;
        logic            calc_ready;
        logic [63:0]     calc_result;
        logic [4:0]      calc_flags;
    } fp_check_in_type;

    // Status outputs (counters are width-parameterised and kept separate)
    typedef struct packed {
        logic        exp_ready;
        logic        fail;
        logic        orphan;
        logic        overflow;
        logic        timeout;
        logic        idle;
        logic [63:0] cap_ref_result;
        logic [63:0] cap_calc_result;
        logic [4:0]  cap_ref_flags;
        logic [4:0]  cap_calc_flags;
    } fp_check_out_type;

    // Result compare; a canonical NaN from the unit matches any quiet NaN
    // reference when the op allows NaN relaxation.
    function automatic logic result_match(input fp_check_entry_t e,
                                          input logic [63:0]     calc);
        logic m;
        if (e.fmt == FMT_DOUBLE) begin
            if (e.nan_rlx && (calc == CANON_NAN_D))
                m = (e.result[62:51] == 12'hFFF);
            else
                m = (e.result == calc);
        end else begin
            if (e.nan_rlx && (calc[31:0] == CANON_NAN_S))
                m = (e.result[30:22] == 9'h1FF);
            else
                m = (e.result[31:0] == calc[31:0]);
        end
        return m;
    endfunction

endpackage

// File: rtl/fp_check_if.sv
// fp_check_if: expected-entry push, fp_unit result and checker status bundle.
// master = issue side / environment, slave = fp_check.
interface fp_check_if #(
    parameter int CNT_W = 32
);
    logic             exp_valid;
    logic [63:0]      exp_result;
    logic [4:0]       exp_flags;
    logic [1:0]       exp_fmt;
    logic             exp_nan_rlx;
    logic             exp_ready;

    logic             calc_ready;
    logic [63:0]      calc_result;
    logic [4:0]       calc_flags;

    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             fail;
    logic             orphan;
    logic             overflow;
    logic             timeout;
    logic             idle;
    logic [63:0]      cap_ref_result;
    logic [63:0]      cap_calc_result;
    logic [4:0]       cap_ref_flags;
    logic [4:0]       cap_calc_flags;

    modport master (
        output exp_valid, exp_result, exp_flags, exp_fmt, exp_nan_rlx,
        output calc_ready, calc_result, calc_flags,
        input  exp_ready, pass_cnt, fail_cnt, fail, orphan, overflow,
        input  timeout, idle, cap_ref_result, cap_calc_result,
        input  cap_ref_flags, cap_calc_flags
    );

    modport slave (
        input  exp_valid, exp_result, exp_flags, exp_fmt, exp_nan_rlx,
        input  calc_ready, calc_result, calc_flags,
        output exp_ready, pass_cnt, fail_cnt, fail, orphan, overflow,
        output timeout, idle, cap_ref_result, cap_calc_result,
        output cap_ref_flags, cap_calc_flags
    );
endinterface

// File: rtl/fp_check_fifo.sv
// fp_check_fifo: synchronous FIFO holding expected entries. Pointers carry
// one extra wrap bit so full and empty are distinguishable; a push while
// full is dropped and reported, a pop while empty is ignored and reported.
module fp_check_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 72
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             popped,
    output logic             dropped,
    output logic             underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pushed;

    // Status decode straight from the pointer registers
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pushed    = push && !full;
        dropped   = push && full;
        popped    = pop && !empty;
        underflow = pop && empty;
        pop_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer advance; wrap-around is the natural modulo of the counter
    always_comb begin
        // NOTE: every combinational output gets a value on all paths, so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pushed) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (popped) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array
    always_ff @(posedge clock) begin
        // NOTE: the array is not reset; empty pointers make stale contents unreachable.
        if (pushed) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fp_check.sv
// fp_check: in-order result checker downstream of fp_unit. Expected results
// are queued at issue; each calc_ready pops one entry into a compare stage,
// and the following stage updates counters, sticky status and the
// first-failure capture.
// Optional: define FP_CHECK_TIMEOUT_EN to enable the stall watchdog.
module fp_check
    import fp_check_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic  clock,
    input  logic  reset,
    fp_check_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FAIL = 2'd2;
    localparam int         EW     = $bits(fp_check_entry_t);

    fp_check_in_type  in_s;
    fp_check_out_type out_s;

    logic [EW-1:0]   fifo_rd_data;
    fp_check_entry_t head;
    logic            fifo_full, fifo_empty, fifo_popped;
    logic            fifo_dropped, fifo_underflow;

    logic            s1_valid_q, s1_valid_d;
    fp_check_entry_t s1_entry_q, s1_entry_d;
    logic [63:0]     s1_calc_result_q, s1_calc_result_d;
    logic [4:0]      s1_calc_flags_q, s1_calc_flags_d;
    logic            s1_match;

    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             orphan_q, orphan_d;
    logic             overflow_q, overflow_d;
    logic [1:0]       state_q, state_d;
    logic [63:0]      cap_ref_result_q, cap_ref_result_d;
    logic [63:0]      cap_calc_result_q, cap_calc_result_d;
    logic [4:0]       cap_ref_flags_q, cap_ref_flags_d;
    logic [4:0]       cap_calc_flags_q, cap_calc_flags_d;
    logic             timeout_w;

    // Gather interface inputs into the package bundle
    always_comb begin
        in_s.exp_valid       = bus.exp_valid;
        in_s.exp.result      = bus.exp_result;
        in_s.exp.flags       = bus.exp_flags;
        in_s.exp.fmt         = bus.exp_fmt;
        in_s.exp.nan_rlx     = bus.exp_nan_rlx;
        in_s.calc_ready      = bus.calc_ready;
        in_s.calc_result     = bus.calc_result;
        in_s.calc_flags      = bus.calc_flags;
    end

    fp_check_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_s.exp_valid),
        .push_data (in_s.exp),
        .pop       (in_s.calc_ready),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .popped    (fifo_popped),
        .dropped   (fifo_dropped),
        .underflow (fifo_underflow)
    );

    assign head = fp_check_entry_t'(fifo_rd_data);

    // Stage 1: capture the popped entry with the unit's result
    always_comb begin
        s1_valid_d       = fifo_popped;
        s1_entry_d       = s1_entry_q;
        s1_calc_result_d = s1_calc_result_q;
        s1_calc_flags_d  = s1_calc_flags_q;
        if (fifo_popped) begin
            s1_entry_d       = head;
            s1_calc_result_d = in_s.calc_result;
            s1_calc_flags_d  = in_s.calc_flags;
        end
    end

    // Compare the stage-1 pair: result rule plus exact flags
    always_comb begin
        s1_match = result_match(s1_entry_q, s1_calc_result_q) &&
                   (s1_entry_q.flags == s1_calc_flags_q);
    end

    // Stage 2: counters, sticky status, first-failure capture and FSM
    always_comb begin
        pass_cnt_d        = pass_cnt_q;
        fail_cnt_d        = fail_cnt_q;
        orphan_d          = orphan_q | fifo_underflow;
        overflow_d        = overflow_q | fifo_dropped;
        cap_ref_result_d  = cap_ref_result_q;
        cap_calc_result_d = cap_calc_result_q;
        cap_ref_flags_d   = cap_ref_flags_q;
        cap_calc_flags_d  = cap_calc_flags_q;
        state_d           = state_q;

        if (s1_valid_q && s1_match && (pass_cnt_q != '1))
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
        if (s1_valid_q && !s1_match && (fail_cnt_q != '1))
            fail_cnt_d = fail_cnt_q + CNT_W'(1);

        if (state_q != S_FAIL && s1_valid_q && !s1_match) begin
            cap_ref_result_d  = s1_entry_q.result;
            cap_calc_result_d = s1_calc_result_q;
            cap_ref_flags_d   = s1_entry_q.flags;
            cap_calc_flags_d  = s1_calc_flags_q;
        end

        case (state_q)
            S_FAIL:  state_d = S_FAIL;
            default: begin
                if (s1_valid_q && !s1_match)      state_d = S_FAIL;
                else if (!fifo_empty || s1_valid_q) state_d = S_BUSY;
                else                              state_d = S_IDLE;
            end
        endcase
    end

    // Pipeline and status registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid_q        <= 1'b0;
            s1_entry_q        <= '0;
            s1_calc_result_q  <= '0;
            s1_calc_flags_q   <= '0;
            pass_cnt_q        <= '0;
            fail_cnt_q        <= '0;
            orphan_q          <= 1'b0;
            overflow_q        <= 1'b0;
            state_q           <= S_IDLE;
            cap_ref_result_q  <= '0;
            cap_calc_result_q <= '0;
            cap_ref_flags_q   <= '0;
            cap_calc_flags_q  <= '0;
        end else begin
            s1_valid_q        <= s1_valid_d;
            s1_entry_q        <= s1_entry_d;
            s1_calc_result_q  <= s1_calc_result_d;
            s1_calc_flags_q   <= s1_calc_flags_d;
            pass_cnt_q        <= pass_cnt_d;
            fail_cnt_q        <= fail_cnt_d;
            orphan_q          <= orphan_d;
            overflow_q        <= overflow_d;
            state_q           <= state_d;
            cap_ref_result_q  <= cap_ref_result_d;
            cap_calc_result_q <= cap_calc_result_d;
            cap_ref_flags_q   <= cap_ref_flags_d;
            cap_calc_flags_q  <= cap_calc_flags_d;
        end
    end

`ifdef FP_CHECK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    // Watchdog: count stalled cycles while entries wait for a result
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (fifo_empty || in_s.calc_ready)
            wd_cnt_d = '0;
        else if (wd_cnt_q != WD_W'(TIMEOUT))
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (wd_cnt_d == WD_W'(TIMEOUT))
            timeout_d = 1'b1;
    end

    // Watchdog registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_w = timeout_q;
`else
    assign timeout_w = 1'b0;
`endif

    // Assemble status bundle from registers only
    always_comb begin
        out_s.exp_ready       = !fifo_full;
        out_s.fail            = (state_q == S_FAIL);
        out_s.orphan          = orphan_q;
        out_s.overflow        = overflow_q;
        out_s.timeout         = timeout_w;
        out_s.idle            = fifo_empty && !s1_valid_q;
        out_s.cap_ref_result  = cap_ref_result_q;
        out_s.cap_calc_result = cap_calc_result_q;
        out_s.cap_ref_flags   = cap_ref_flags_q;
        out_s.cap_calc_flags  = cap_calc_flags_q;
    end

    assign bus.exp_ready       = out_s.exp_ready;
    assign bus.pass_cnt        = pass_cnt_q;
    assign bus.fail_cnt        = fail_cnt_q;
    assign bus.fail            = out_s.fail;
    assign bus.orphan          = out_s.orphan;
    assign bus.overflow        = out_s.overflow;
    assign bus.timeout         = out_s.timeout;
    assign bus.idle            = out_s.idle;
    assign bus.cap_ref_result  = out_s.cap_ref_result;
    assign bus.cap_calc_result = out_s.cap_calc_result;
    assign bus.cap_ref_flags   = out_s.cap_ref_flags;
    assign bus.cap_calc_flags  = out_s.cap_calc_flags;

endmodule

// File: tb/tb_fp_check.sv
// tb_fp_check: directed and randomized checks of fp_check against a
// transaction-level reference model (queue of expected entries, two-cycle
// result latency). Counter width is reduced so saturation is reachable.
module tb_fp_check;
    import fp_check_pkg::*;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int TIMEOUT = 64;

    logic clk;
    logic rst_n;

    fp_check_if #(.CNT_W(CNT_W)) bus ();

    fp_check #(
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    fp_check_entry_t mq[$];
    int              m_pass, m_fail, m_wd;
    bit              m_failst, m_orph, m_over, m_tmo;
    bit              pv, pp;
    fp_check_entry_t pe;
    logic [63:0]     pcr;
    logic [4:0]      pcf;
    logic [63:0]     m_cap_ref, m_cap_calc;
    logic [4:0]      m_cap_rf, m_cap_cf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic fp_check_entry_t mk(input logic [63:0] r, input logic [4:0] f,
                                           input logic [1:0] fmt, input logic rlx);
        fp_check_entry_t e;
        e.result = r; e.flags = f; e.fmt = fmt; e.nan_rlx = rlx;
        return e;
    endfunction

    // Expected outcome written from the IEEE view: quiet NaN = all-ones exponent with quiet bit
    function automatic bit ref_pass(input fp_check_entry_t e, input logic [63:0] cr, input logic [4:0] cf);
        bit dbl, canon, ref_qnan, res_ok;
        dbl = (e.fmt == 2'd1);
        if (dbl) begin
            canon    = (cr == 64'h7FF8_0000_0000_0000);
            ref_qnan = (e.result[62:52] == 11'h7FF) && e.result[51];
            res_ok   = (e.nan_rlx && canon) ? ref_qnan : (e.result == cr);
        end else begin
            canon    = (cr[31:0] == 32'h7FC0_0000);
            ref_qnan = (e.result[30:23] == 8'hFF) && e.result[22];
            res_ok   = (e.nan_rlx && canon) ? ref_qnan : (e.result[31:0] == cr[31:0]);
        end
        return res_ok && (e.flags == cf);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_pass = 0; m_fail = 0; m_wd = 0;
        m_failst = 0; m_orph = 0; m_over = 0; m_tmo = 0;
        pv = 0; pp = 0;
        m_cap_ref = '0; m_cap_calc = '0; m_cap_rf = '0; m_cap_cf = '0;
    endtask

    task automatic drive(input bit push, input fp_check_entry_t e, input bit pop,
                         input logic [63:0] cr, input logic [4:0] cf);
        bus.exp_valid   = push;
        bus.exp_result  = e.result;
        bus.exp_flags   = e.flags;
        bus.exp_fmt     = e.fmt;
        bus.exp_nan_rlx = e.nan_rlx;
        bus.calc_ready  = pop;
        bus.calc_result = cr;
        bus.calc_flags  = cf;
    endtask

    // One clock: drive, advance the model by one edge, settle at negedge
    task automatic step(input bit push, input fp_check_entry_t e, input bit pop,
                        input logic [63:0] cr, input logic [4:0] cf);
        int pre;
        drive(push, e, pop, cr, cf);
        @(posedge clk);
        // The compare popped one edge ago becomes visible now
        if (pv) begin
            if (pp) begin
                if (m_pass < CNT_MAX) m_pass++;
            end else begin
                if (m_fail < CNT_MAX) m_fail++;
                if (!m_failst) begin
                    m_cap_ref = pe.result; m_cap_calc = pcr;
                    m_cap_rf  = pe.flags;  m_cap_cf   = pcf;
                end
                m_failst = 1;
            end
        end
        pre = mq.size();
`ifdef FP_CHECK_TIMEOUT_EN
        if (pre == 0 || pop) m_wd = 0;
        else m_wd++;
        if (m_wd >= TIMEOUT) m_tmo = 1;
`endif
        pv = 0;
        if (pop) begin
            if (pre == 0) m_orph = 1;
            else begin
                pe  = mq.pop_front();
                pv  = 1;
                pp  = ref_pass(pe, cr, cf);
                pcr = cr;
                pcf = cf;
            end
        end
        if (push) begin
            if (pre == DEPTH) m_over = 1;
            else mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, '0, '0);
        rst_n = 1'b0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all();
        check("pass_cnt",  64'(bus.pass_cnt),       64'(m_pass));
        check("fail_cnt",  64'(bus.fail_cnt),       64'(m_fail));
        check("fail",      64'(bus.fail),           64'(m_failst));
        check("orphan",    64'(bus.orphan),         64'(m_orph));
        check("overflow",  64'(bus.overflow),       64'(m_over));
        check("timeout",   64'(bus.timeout),        64'(m_tmo));
        check("exp_ready", 64'(bus.exp_ready),      64'(mq.size() != DEPTH));
        check("idle",      64'(bus.idle),           64'(mq.size() == 0 && !pv));
        check("cap_ref",   bus.cap_ref_result,      m_cap_ref);
        check("cap_calc",  bus.cap_calc_result,     m_cap_calc);
        check("cap_rflg",  64'(bus.cap_ref_flags),  64'(m_cap_rf));
        check("cap_cflg",  64'(bus.cap_calc_flags), 64'(m_cap_cf));
    endtask

    function automatic fp_check_entry_t rand_entry();
        logic [4:0] f;
        f = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
        case ($urandom_range(0, 5))
            0:       return mk(64'h0000_0000_3F80_0000, f, 2'd0, 1'b1);
            1:       return mk(64'h0000_0000_7FC0_0001, f, 2'd0, 1'($urandom));
            2:       return mk(64'h0000_0000_FFC0_0000, f, 2'd0, 1'($urandom));
            3:       return mk(64'h4000_0000_0000_0000, f, 2'd1, 1'b1);
            4:       return mk(64'h7FF8_0000_0000_0001, f, 2'd1, 1'($urandom));
            default: return mk(64'h7FF0_0000_0000_0001, f, 2'd1, 1'b1);
        endcase
    endfunction

    fp_check_entry_t one_s, e;
    logic [63:0]     cr;
    logic [4:0]      cf;
    bit              exp_tmo;

    initial begin
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        do_reset();
        check_all();
        check("rst_exp_ready", 64'(bus.exp_ready), 64'd1);
        check("rst_idle",      64'(bus.idle),      64'd1);

        // Three matching single-precision results
        one_s = mk(64'h0000_0000_3F80_0000, 5'd0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin step(1'b1, one_s, 1'b0, '0, '0); check_all(); end
        for (int i = 0; i < 3; i++) begin step(1'b0, '0, 1'b1, 64'h3F80_0000, 5'd0); check_all(); end
        idle_step(); check_all();
        idle_step(); check_all();
        check("t1_pass", 64'(bus.pass_cnt), 64'd3);
        check("t1_fail", 64'(bus.fail),     64'd0);
        check("t1_idle", 64'(bus.idle),     64'd1);

        // NaN relaxation on, then off
        step(1'b1, mk(64'h7FC0_0001, 5'd0, 2'd0, 1'b1), 1'b0, '0, '0); check_all();
        step(1'b0, '0, 1'b1, 64'h7FC0_0000, 5'd0); check_all();
        step(1'b1, mk(64'h7FC0_0001, 5'd0, 2'd0, 1'b0), 1'b0, '0, '0); check_all();
        step(1'b0, '0, 1'b1, 64'h7FC0_0000, 5'd0); check_all();
        idle_step(); check_all();
        idle_step(); check_all();
        check("nan_pass",    64'(bus.pass_cnt), 64'd4);
        check("nan_failcnt", 64'(bus.fail_cnt), 64'd1);
        check("nan_fail",    64'(bus.fail),     64'd1);
        check("nan_cap_ref", bus.cap_ref_result, 64'h7FC0_0001);

        // Double-precision flag mismatch, then a later mismatch with capture frozen
        do_reset(); check_all();
        step(1'b1, mk(64'h3FF0_0000_0000_0000, 5'h01, 2'd1, 1'b1), 1'b0, '0, '0); check_all();
        step(1'b1, mk(64'h4000_0000_0000_0000, 5'h00, 2'd1, 1'b1), 1'b1,
             64'h3FF0_0000_0000_0000, 5'h00); check_all();
        step(1'b0, '0, 1'b1, 64'h4000_0000_0000_0001, 5'h00); check_all();
        idle_step(); check_all();
        idle_step(); check_all();
        check("dbl_failcnt", 64'(bus.fail_cnt),       64'd2);
        check("dbl_cap_ref", bus.cap_ref_result,      64'h3FF0_0000_0000_0000);
        check("dbl_cap_rf",  64'(bus.cap_ref_flags),  64'h01);
        check("dbl_cap_cf",  64'(bus.cap_calc_flags), 64'h00);

        // Fill past full, push-while-full with a pop, then drain
        do_reset(); check_all();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, mk(64'h3F80_0000 + 64'(i), 5'd0, 2'd0, 1'b0), 1'b0, '0, '0);
            check_all();
            if (i == 7) begin
                check("full_ready",  64'(bus.exp_ready), 64'd0);
                check("full_noovf",  64'(bus.overflow),  64'd0);
            end
        end
        check("ovf_set", 64'(bus.overflow), 64'd1);
        step(1'b1, mk(64'h1234, 5'd0, 2'd0, 1'b0), 1'b1, 64'h3F80_0000, 5'd0); check_all();
        for (int i = 1; i < 8; i++) begin
            step(1'b0, '0, 1'b1, 64'h3F80_0000 + 64'(i), 5'd0); check_all();
        end
        idle_step(); check_all();
        idle_step(); check_all();
        check("drain_pass", 64'(bus.pass_cnt), 64'd8);
        check("drain_idle", 64'(bus.idle),     64'd1);

        // Pop on empty, and pop+push on empty (no bypass)
        step(1'b0, '0, 1'b1, 64'h3F80_0000, 5'd0); check_all();
        check("orphan_set", 64'(bus.orphan),   64'd1);
        step(1'b1, one_s, 1'b1, 64'h3F80_0000, 5'd0); check_all();
        idle_step(); check_all();
        check("orphan_cnt", 64'(bus.pass_cnt), 64'd8);
        check("nobypass",   64'(bus.idle),     64'd0);

        // Reset in the middle of traffic
        step(1'b1, one_s, 1'b1, 64'h3F80_0000, 5'd0); check_all();
        do_reset(); check_all();
        check("mid_rst_pass",   64'(bus.pass_cnt), 64'd0);
        check("mid_rst_orphan", 64'(bus.orphan),   64'd0);
        idle_step(); idle_step(); check_all();

        // Stall watchdog
        step(1'b1, one_s, 1'b0, '0, '0); check_all();
        for (int i = 0; i < TIMEOUT + 6; i++) begin idle_step(); check_all(); end
`ifdef FP_CHECK_TIMEOUT_EN
        exp_tmo = 1'b1;
`else
        exp_tmo = 1'b0;
`endif
        check("wd_timeout", 64'(bus.timeout), 64'(exp_tmo));
        step(1'b0, '0, 1'b1, 64'h3F80_0000, 5'd0); check_all();
        idle_step(); check_all();

        // Randomized traffic with saturation of the narrow counters
        do_reset(); check_all();
        for (int i = 0; i < 400; i++) begin
            e  = rand_entry();
            cr = {$urandom, $urandom};
            cf = 5'($urandom);
            if (mq.size() > 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: cr = mq[0].result;
                    5, 6:          cr = (mq[0].fmt == 2'd1) ? 64'h7FF8_0000_0000_0000
                                                            : 64'h0000_0000_7FC0_0000;
                    default:       cr = {$urandom, $urandom};
                endcase
                if ($urandom_range(0, 4) != 0) cf = mq[0].flags;
            end
            step(1'($urandom_range(0, 1)), e, ($urandom_range(0, 2) != 0), cr, cf);
            check_all();
        end
        idle_step(); idle_step(); check_all();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_check.md
Name: fp_check

Overview:
Synthesizable result checker that sits directly downstream of fp_unit and consumes fp_exe_o results. The issue side pushes the expected result, expected flags and format into an in-order queue as each op is issued. Each fp_unit ready pulse pops one entry and compares it with the calculated output, using a NaN-relaxed compare. The block keeps pass/fail counters, sticky error status and a capture of the first failure, for use by FPGA self-test and for bench reuse.

Parameters:
DEPTH, 8, expected-queue entries; power of two, ≥2
CNT_W, 32, width of pass/fail counters
TIMEOUT, 64, watchdog limit in cycles (used only with FP_CHECK_TIMEOUT_EN)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-low reset
exp_valid  in  1  push expected entry
exp_result  in  64  reference result; single format in [31:0]
exp_flags  in  5  reference flags (NV,DZ,OF,UF,NX)
exp_fmt  in  2  0=single, 1=double
exp_nan_rlx  in  1  apply NaN-relaxed compare; 0 for fcvt_f2i/fcmp ops
exp_ready  out  1  queue not full
calc_ready  in  1  fp_exe_o.ready
calc_result  in  64  fp_exe_o.result
calc_flags  in  5  fp_exe_o.flags
pass_cnt  out  CNT_W  matched results
fail_cnt  out  CNT_W  mismatched results
fail  out  1  sticky: any mismatch
orphan  out  1  sticky: calc_ready with queue empty
overflow  out  1  sticky: exp_valid while full; entry dropped
timeout  out  1  sticky watchdog (0 when feature absent)
idle  out  1  queue empty and no compare pending
cap_ref_result, cap_calc_result  out  64  first-failure results
cap_ref_flags, cap_calc_flags  out  5  first-failure flags

Behaviour:
- Reset (reset==0 at clock edge): pointers, counters, sticky bits, capture registers and FSM cleared; exp_ready=1, idle=1, all other outputs 0. Reset mid-operation discards queued entries and any pending compare.
- Queue: read/write pointers are log2(DEPTH)+1 bits wide; the MSB distinguishes full from empty; wrap-around is natural. exp_ready=!full, combinational from registers only.
- Push when full: entry dropped and overflow set, even if calc_ready pops in the same cycle.
- Simultaneous push and pop when neither full nor empty: both take effect; occupancy unchanged.
- Pop on empty: orphan set; no compare performed. A push in the same cycle is not bypassed.
- Compare pipeline: stage 1 registers {entry, calc_result, calc_flags} on pop; stage 2 updates counters, sticky bits and capture. Latency from calc_ready to pass_cnt/fail_cnt change is 2 clocks. Back-to-back ready pulses are sustained at 1 per cycle.
- Result match, single format: if exp_nan_rlx && calc[31:0]==32'h7FC00000, match iff ref[30:22]==9'h1FF. Otherwise match iff ref[31:0]==calc[31:0]. Bits [63:32] are ignored.
- Result match, double format: if exp_nan_rlx && calc==64'h7FF8000000000000, match iff ref[62:51]==12'hFFF. Otherwise full 64-bit equality.
- Flags: match iff all 5 bits are equal. The op passes iff result and flags both match.
- Counters saturate at all-ones and never wrap.
- FSM states:
  - S_IDLE: queue empty, no compare pending.
  - S_BUSY: entries outstanding or compare in flight.
  - S_FAIL: first failure captured.
- FSM transitions: S_IDLE↔S_BUSY follow occupancy or pending compare. Any fail moves to S_FAIL. S_FAIL is absorbing until reset. In S_FAIL, capture registers are frozen, but the queue still drains and counters keep counting.
- idle = queue empty && no stage-1 valid, in any state.

Optional Feature:
FP_CHECK_TIMEOUT_EN:
- Defined: a watchdog counter increments each cycle the queue is non-empty and calc_ready==0. It clears on calc_ready or when the queue is empty. Reaching TIMEOUT sets sticky timeout.
- Undefined: no counter is instantiated and timeout is tied to 0.

Decomposition:
- Package fp_wire gains fp_check_in_type and fp_check_out_type structs, the queue entry struct {result,flags,fmt,nan_rlx}, and constants for the canonical NaNs 32'h7FC00000 and 64'h7FF8000000000000.
- Sub-module fp_check_fifo: parameterised synchronous FIFO with full/empty, push/pop and drop-on-full reporting.

Test Plan:
- Push 3 entries (ref 0x3F800000, flags 0, fmt 0), then 3 ready pulses with equal data -> pass_cnt=3 two cycles after the last pulse, fail=0, idle=1.
- Push ref 0x7FC00001, nan_rlx=1; calc 0x7FC00000 -> pass. Repeat with nan_rlx=0 -> fail=1, fail_cnt=1, cap_ref_result=0x7FC00001.
- Double: ref 0x3FF0000000000000 flags 0x01, calc same result with flags 0x00 -> fail. A later mismatch leaves the capture unchanged and fail_cnt=2.
- Push 9 entries with DEPTH=8 and no pops -> overflow=1, exp_ready=0 after the 8th push. Pop 8 -> all compared, then idle=1.
- calc_ready with queue empty -> orphan=1, counters unchanged. Reset low for 1 cycle mid-stream -> all outputs return to reset values.
- With FP_CHECK_TIMEOUT_EN, TIMEOUT=64: push 1 entry, no ready for 64 cycles -> timeout=1. Without the macro -> timeout stays 0.
